// File: rtl/riscv_dbus_bridge.sv
// riscv_dbus_bridge: turns the single-cycle core's load/store port into a
// req/ack transaction on a variable-latency data bus. The core is stalled
// from the moment a memory op appears until the bus acks or the WAIT timer
// expires. Load data is returned in the single DONE cycle where stall drops.
`timescale 1ns/1ps

module riscv_dbus_bridge #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic        core_mem_read,
  input  logic        core_mem_write,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic [31:0] stall_count
);

  // Timer only has to reach TIMEOUT_CYCLES-1 before expiry is declared.
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [TIMER_W-1:0] timer;
  logic               core_req;
  logic               accept;
  logic               complete;
  logic               expire;

  // Byte address to bus word address; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Free-running wrap-around increment for the stall statistic.
  function automatic logic [31:0] wrap_inc(input logic [31:0] value);
    return value + 32'd1;
  endfunction

  assign core_req = core_mem_read | core_mem_write;

  // Stall must drop in DONE with no extra latency, so it is decoded
  // straight from the state and the live core request.
  assign core_stall = ((state == IDLE) && core_req) || (state == WAIT);
  assign bus_req    = (state == WAIT);

  // Next-state decode; ack takes priority over timer expiry.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (core_req) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus_ack) begin
          complete   = 1'b1;
          state_next = DONE;
        end else if (timer == TIMER_LAST) begin
          expire     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the op at acceptance; the core may rewrite rs1 while stalled,
  // so the bus side never looks at core inputs again until the next IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_we    <= 1'b0;
    end else if (accept) begin
      bus_addr  <= word_align(core_addr);
      bus_wdata <= core_wdata;
      bus_we    <= core_mem_write;
    end
  end

  // WAIT-cycle timer, restarted on every accepted op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (accept) begin
      timer <= '0;
    end else if ((state == WAIT) && !bus_ack) begin
      timer <= timer + 1'b1;
    end
  end

  // Load data capture; stores leave the last returned value in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rdata <= 32'd0;
    end else if (complete && !bus_we) begin
      core_rdata <= bus_rdata;
    end else if (expire && !bus_we) begin
      core_rdata <= ERR_DATA;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if (expire) begin
      bus_err <= 1'b1;
    end
  end

  // Count every edge at which the core is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 32'd0;
    end else if (core_stall) begin
      stall_count <= wrap_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_riscv_dbus_bridge.sv
// Testbench for riscv_dbus_bridge: directed ops push expected bus and
// completion records; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_riscv_dbus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] core_addr = 32'd0;
  logic [31:0] core_wdata = 32'd0;
  logic        core_mem_read = 1'b0;
  logic        core_mem_write = 1'b0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_err;
  logic [31:0] stall_count;

  riscv_dbus_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA      (32'hDEADBEEF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_mem_read (core_mem_read),
    .core_mem_write(core_mem_write),
    .core_rdata    (core_rdata),
    .core_stall    (core_stall),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .bus_err       (bus_err),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          req_len;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    int          stall_len;
    logic [31:0] count;
    logic        err;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: bus transaction fields while bus_req is high, length when it
  // falls; completion record whenever a stall run ends.
  initial begin : monitor
    int req_run;
    int stall_run;
    bus_exp_t  be;
    done_exp_t de;
    req_run = 0;
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        req_run++;
        if (bus_q.size() == 0) begin
          check("bus_q_depth", 32'd0, 32'd1);
        end else begin
          be = bus_q[0];
          check("bus_addr", bus_addr, be.addr);
          check("bus_we", 32'(bus_we), 32'(be.we));
          check("bus_wdata", bus_wdata, be.wdata);
        end
      end else if (req_run > 0) begin
        if (bus_q.size() == 0) begin
          check("bus_q_depth", 32'd0, 32'd1);
        end else begin
          be = bus_q.pop_front();
          check("bus_req_len", 32'(req_run), 32'(be.req_len));
        end
        req_run = 0;
      end
      if (core_stall) begin
        stall_run++;
      end else if (stall_run > 0) begin
        if (done_q.size() == 0) begin
          check("done_q_depth", 32'd0, 32'd1);
        end else begin
          de = done_q.pop_front();
          check("done_rdata", core_rdata, de.rdata);
          check("stall_len", 32'(stall_run), 32'(de.stall_len));
          check("stall_count", stall_count, de.count);
          check("bus_err", 32'(bus_err), 32'(de.err));
        end
        stall_run = 0;
      end
    end
  end

  // One core memory op; k = WAIT cycle carrying the ack (0 = never acked).
  task automatic do_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int k, input logic [31:0] rd, input logic scramble,
                       input logic [31:0] exp_rdata, input int exp_len,
                       input logic [31:0] exp_cnt, input logic exp_err);
    int n;
    n = (k == 0) ? TO : k;
    bus_q.push_back('{addr & 32'hFFFF_FFFC, wr, wdata, n});
    done_q.push_back('{exp_rdata, exp_len, exp_cnt, exp_err});
    core_addr      = addr;
    core_wdata     = wdata;
    core_mem_read  = !wr;
    core_mem_write = wr;
    @(posedge clk); #1;
    for (int i = 1; i <= n; i++) begin
      if (scramble && i == 1) begin
        core_addr      = 32'hFFFF_FFF0;
        core_wdata     = 32'h0F0F_0F0F;
        core_mem_read  = 1'b1;
        core_mem_write = 1'b1;
      end
      if (i == k) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
      end
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = 32'd0;
    end
    @(posedge clk); #1;
    core_mem_read  = 1'b0;
    core_mem_write = 1'b0;
    core_addr      = 32'd0;
    core_wdata     = 32'd0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(core_stall), 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    check("rst_count", stall_count, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // lw 0x100, ack in WAIT 3
    do_op(1'b0, 32'h100, 32'h0, 3, 32'h12345678, 1'b0, 32'h12345678, 4, 32'd4, 1'b0);
    // sw 0x203, ack in WAIT 1; rdata unchanged
    do_op(1'b1, 32'h203, 32'hA5A5A5A5, 1, 32'h0, 1'b0, 32'h12345678, 2, 32'd6, 1'b0);
    // back-to-back lw/lw/sw, latency 2, core inputs rewritten mid-WAIT
    do_op(1'b0, 32'h300, 32'h0, 2, 32'h11111111, 1'b1, 32'h11111111, 3, 32'd9, 1'b0);
    do_op(1'b0, 32'h304, 32'h0, 2, 32'h22222222, 1'b1, 32'h22222222, 3, 32'd12, 1'b0);
    do_op(1'b1, 32'h308, 32'h33333333, 2, 32'h0, 1'b1, 32'h22222222, 3, 32'd15, 1'b0);
    // ack in the same cycle as expiry: normal completion
    do_op(1'b0, 32'h400, 32'h0, 4, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 5, 32'd20, 1'b0);
    // timeout
    do_op(1'b0, 32'h501, 32'h0, 0, 32'h0, 1'b0, 32'hDEADBEEF, 5, 32'd25, 1'b1);
    // error flag persists across good ops
    do_op(1'b1, 32'h604, 32'h0BADF00D, 1, 32'h0, 1'b0, 32'hDEADBEEF, 2, 32'd27, 1'b1);
    do_op(1'b0, 32'h700, 32'h0, 2, 32'h77777777, 1'b0, 32'h77777777, 3, 32'd30, 1'b1);

    // reset in WAIT 2, then a late ack after release
    bus_q.push_back('{32'h800, 1'b0, 32'h0, 1});
    done_q.push_back('{32'h0, 2, 32'd0, 1'b0});
    core_addr     = 32'h800;
    core_mem_read = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst           = 1'b1;
    core_mem_read = 1'b0;
    core_addr     = 32'd0;
    #1;
    check("async_bus_req", 32'(bus_req), 32'd0);
    check("async_stall", 32'(core_stall), 32'd0);
    check("async_rdata", core_rdata, 32'd0);
    check("async_count", stall_count, 32'd0);
    check("async_err", 32'(bus_err), 32'd0);
    check("async_bus_addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h99999999;
    @(posedge clk); #1;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    check("late_ack_bus_req", 32'(bus_req), 32'd0);
    check("late_ack_stall", 32'(core_stall), 32'd0);
    check("late_ack_rdata", core_rdata, 32'd0);
    check("late_ack_count", stall_count, 32'd0);
    @(posedge clk); #1;
    check("late_ack_idle", 32'(bus_req), 32'd0);

    // normal operation after reset
    do_op(1'b0, 32'h900, 32'h0, 1, 32'h5A5A5A5A, 1'b0, 32'h5A5A5A5A, 2, 32'd2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("bus_q_left", 32'(bus_q.size()), 32'd0);
    check("done_q_left", 32'(done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
